controller: RTL and testbench

Multicycle MIPS control unit with interrupt handling. Decodes `op`/`funct` from the instruction register and runs a Moore FSM. Each state drives the datapath strobes and mux selects: PC, memory, IR, ALU and register file. Sits beside the multicycle datapath; maskable (INT) and non-maskable (NMI) interrupts are accepted only at instruction boundaries.

---
 rtl/controller.sv | 181 ++++++++++++++++++
 tb/tb_controller.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/controller.sv
// Multicycle MIPS control unit: Moore FSM driving datapath strobes and mux
// selects, with optional interrupt entry/return handling.
// Optional feature macro: CONTROLLER_INT_EN (INT/NMI/INTD handling, INTR and
// RFE states). Without it the interrupt inputs are ignored.
module controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       INT,
  input  logic       NMI,
  input  logic       INTD,
  output logic       isBranch,
  output logic       pcWrite,
  output logic       lorD,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       INA,
  output logic [1:0] aluControl,
  output logic [1:0] aluSrcB,
  output logic       PCSource,
  output logic       aluSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       isInterrupted
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC, S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB
`ifdef CONTROLLER_INT_EN
    , S_INTR, S_RFE
`endif
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`ifdef CONTROLLER_INT_EN
  localparam logic [5:0] OP_COP0  = 6'b010000;
  localparam logic [5:0] FN_RFE   = 6'b011000;
`endif

  state_t     r_state;
  state_t     w_next;
  state_t     w_ret;      // target of any transition that ends an instruction
  logic       w_funct_ok;
  logic [1:0] w_alu_fn;

`ifdef CONTROLLER_INT_EN
  logic r_is_int;
  logic r_nmi_pend;
  logic r_nmi_q;
  logic w_nmi_rise;
  logic w_pending;

  assign w_nmi_rise = NMI & ~r_nmi_q;
  assign w_pending  = r_nmi_pend | (INT & ~INTD & ~r_is_int);
  assign w_ret      = w_pending ? S_INTR : S_FETCH;
`else
  logic w_unused;
  assign w_unused = ^{INT, NMI, INTD};
  assign w_ret    = S_FETCH;
`endif

  // R-type funct decode to ALU operation
  always_comb begin
    w_funct_ok = 1'b1;
    w_alu_fn   = 2'b00;
    case (funct)
      6'b100000: w_alu_fn = 2'b00;
      6'b100010: w_alu_fn = 2'b01;
      6'b100100: w_alu_fn = 2'b10;
      6'b100101: w_alu_fn = 2'b11;
      default:   w_funct_ok = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

`ifdef CONTROLLER_INT_EN
  // NMI edge latch and in-service flag; a fresh NMI edge outranks the clear
  always_ff @(posedge clk) begin
    if (reset) begin
      r_is_int   <= 1'b0;
      r_nmi_pend <= 1'b0;
      r_nmi_q    <= 1'b0;
    end else begin
      r_nmi_q <= NMI;
      if (w_nmi_rise)            r_nmi_pend <= 1'b1;
      else if (w_next == S_INTR) r_nmi_pend <= 1'b0;
      if (w_next == S_INTR)       r_is_int <= 1'b1;
      else if (r_state == S_RFE)  r_is_int <= 1'b0;
    end
  end
`endif

  // Next-state logic
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_RTYPE:     w_next = w_funct_ok ? S_EXEC : w_ret;
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEX;
`ifdef CONTROLLER_INT_EN
          OP_COP0:      w_next = (funct == FN_RFE) ? S_RFE : w_ret;
`endif
          default:      w_next = w_ret;
        endcase
      end
      S_MEMADR: w_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  w_next = S_MEMWB;
      S_EXEC:   w_next = S_ALUWB;
      S_ADDIEX: w_next = S_ADDIWB;
      S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_ADDIWB: w_next = w_ret;
`ifdef CONTROLLER_INT_EN
      S_INTR:   w_next = S_FETCH;
      S_RFE:    w_next = w_ret;
`endif
      default:  w_next = S_FETCH;
    endcase
  end

  // Moore outputs from the registered state, forced low during reset
  always_comb begin
    isBranch      = 1'b0;
    pcWrite       = 1'b0;
    lorD          = 1'b0;
    MemWrite      = 1'b0;
    MemtoReg      = 1'b0;
    IRWrite       = 1'b0;
    INA           = 1'b0;
    aluControl    = 2'b00;
    aluSrcB       = 2'b00;
    PCSource      = 1'b0;
    aluSrcA       = 1'b0;
    RegWrite      = 1'b0;
    RegDst        = 1'b0;
    isInterrupted = 1'b0;
    if (!reset) begin
`ifdef CONTROLLER_INT_EN
      isInterrupted = r_is_int;
`endif
      case (r_state)
        S_FETCH:  begin IRWrite = 1'b1; pcWrite = 1'b1; aluSrcB = 2'b01; end
        S_DECODE: aluSrcB = 2'b11;
        S_MEMADR: begin aluSrcA = 1'b1; aluSrcB = 2'b10; end
        S_MEMRD:  lorD = 1'b1;
        S_MEMWB:  begin MemtoReg = 1'b1; RegWrite = 1'b1; end
        S_MEMWR:  begin lorD = 1'b1; MemWrite = 1'b1; end
        S_EXEC:   begin aluSrcA = 1'b1; aluControl = w_alu_fn; end
        S_ALUWB:  begin RegDst = 1'b1; RegWrite = 1'b1; end
        S_BRANCH: begin
          aluSrcA    = 1'b1;
          aluControl = 2'b01;
          PCSource   = 1'b1;
          isBranch   = 1'b1;
        end
        S_ADDIEX: begin aluSrcA = 1'b1; aluSrcB = 2'b10; end
        S_ADDIWB: RegWrite = 1'b1;
`ifdef CONTROLLER_INT_EN
        S_INTR:   begin INA = 1'b1; pcWrite = 1'b1; end
        S_RFE:    pcWrite = 1'b1;
`endif
        default:  ;
      endcase
    end
  end

endmodule

// File: tb/tb_controller.sv
// Scoreboard bench for controller: expected output vectors are queued per
// instruction as stimulus is set up and compared cycle by cycle at negedge.
module tb_controller;

`ifdef CONTROLLER_INT_EN
  localparam bit INT_EN = 1'b1;
`else
  localparam bit INT_EN = 1'b0;
`endif

  typedef enum {
    B_FETCH, B_DECODE, B_MEMADR, B_MEMRD, B_MEMWB, B_MEMWR, B_EXEC,
    B_ALUWB, B_BRANCH, B_ADDIEX, B_ADDIWB, B_INTR, B_RFE
  } bst_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       INT, NMI, INTD;
  logic       isBranch, pcWrite, lorD, MemWrite, MemtoReg, IRWrite, INA;
  logic [1:0] aluControl, aluSrcB;
  logic       PCSource, aluSrcA, RegWrite, RegDst, isInterrupted;
  logic [15:0] w_obs;

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;
  bit          m_int    = 1'b0;

  logic [15:0] q_vec[$];
  string       q_tag[$];

  controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct),
    .INT(INT), .NMI(NMI), .INTD(INTD),
    .isBranch(isBranch), .pcWrite(pcWrite), .lorD(lorD),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite),
    .INA(INA), .aluControl(aluControl), .aluSrcB(aluSrcB),
    .PCSource(PCSource), .aluSrcA(aluSrcA), .RegWrite(RegWrite),
    .RegDst(RegDst), .isInterrupted(isInterrupted)
  );

  always #50 clk = ~clk;

  assign w_obs = {isBranch, pcWrite, lorD, MemWrite, MemtoReg, IRWrite, INA,
                  aluControl, aluSrcB, PCSource, aluSrcA, RegWrite, RegDst,
                  isInterrupted};

  function automatic logic [1:0] alu_of(input logic [5:0] f);
    case (f)
      6'b100010: return 2'b01;
      6'b100100: return 2'b10;
      6'b100101: return 2'b11;
      default:   return 2'b00;
    endcase
  endfunction

  function automatic bit funct_ok(input logic [5:0] f);
    return (f == 6'b100000) || (f == 6'b100010) ||
           (f == 6'b100100) || (f == 6'b100101);
  endfunction

  function automatic logic [15:0] ev(input bst_t s, input logic [5:0] f, input bit ii);
    logic br, pcw, lrd, mw, m2r, irw, ina, pcs, sa, rw, rd;
    logic [1:0] ac, sb;
    {br, pcw, lrd, mw, m2r, irw, ina, pcs, sa, rw, rd} = '0;
    ac = 2'b00;
    sb = 2'b00;
    case (s)
      B_FETCH:  begin irw = 1; pcw = 1; sb = 2'b01; end
      B_DECODE: sb = 2'b11;
      B_MEMADR: begin sa = 1; sb = 2'b10; end
      B_MEMRD:  lrd = 1;
      B_MEMWB:  begin m2r = 1; rw = 1; end
      B_MEMWR:  begin lrd = 1; mw = 1; end
      B_EXEC:   begin sa = 1; ac = alu_of(f); end
      B_ALUWB:  begin rd = 1; rw = 1; end
      B_BRANCH: begin sa = 1; ac = 2'b01; pcs = 1; br = 1; end
      B_ADDIEX: begin sa = 1; sb = 2'b10; end
      B_ADDIWB: rw = 1;
      B_INTR:   begin ina = 1; pcw = 1; end
      B_RFE:    pcw = 1;
      default:  ;
    endcase
    return {br, pcw, lrd, mw, m2r, irw, ina, ac, sb, pcs, sa, rw, rd, ii};
  endfunction

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic push_state(input bst_t s);
    q_vec.push_back(ev(s, funct, m_int));
    q_tag.push_back(s.name());
  endtask

  task automatic push_zero();
    q_vec.push_back(16'h0000);
    q_tag.push_back("reset");
  endtask

  task automatic push_intr();
    m_int = 1'b1;
    push_state(B_INTR);
  endtask

  // Expected state walk for the instruction currently on op/funct
  task automatic push_instr();
    push_state(B_FETCH);
    push_state(B_DECODE);
    case (op)
      6'b000000: if (funct_ok(funct)) begin push_state(B_EXEC); push_state(B_ALUWB); end
      6'b100011: begin push_state(B_MEMADR); push_state(B_MEMRD); push_state(B_MEMWB); end
      6'b101011: begin push_state(B_MEMADR); push_state(B_MEMWR); end
      6'b000100: push_state(B_BRANCH);
      6'b001000: begin push_state(B_ADDIEX); push_state(B_ADDIWB); end
      6'b010000: if (INT_EN && funct == 6'b011000) begin
        push_state(B_RFE);
        m_int = 1'b0;
      end
      default: ;
    endcase
  endtask

  task automatic drain();
    logic [15:0] e;
    string t;
    while (q_vec.size() > 0) begin
      @(negedge clk);
      e = q_vec.pop_front();
      t = q_tag.pop_front();
      check_eq(t, w_obs, e);
    end
  endtask

  // Change the instruction early in FETCH so DECODE sees it cleanly
  task automatic set_instr(input logic [5:0] o, input logic [5:0] f);
    @(posedge clk);
    #1;
    op    = o;
    funct = f;
  endtask

  logic [11:0] prog [0:9];

  initial begin
    prog[0] = {6'b000000, 6'b100010};
    prog[1] = {6'b000000, 6'b100100};
    prog[2] = {6'b000000, 6'b100101};
    prog[3] = {6'b000000, 6'b100111};
    prog[4] = {6'b100011, 6'b000000};
    prog[5] = {6'b100011, 6'b000000};
    prog[6] = {6'b101011, 6'b000000};
    prog[7] = {6'b000100, 6'b000000};
    prog[8] = {6'b001000, 6'b000000};
    prog[9] = {6'b000010, 6'b000000};

    reset = 1'b1;
    INT = 1'b0; NMI = 1'b0; INTD = 1'b0;
    op = 6'b000000; funct = 6'b100000;

    repeat (3) push_zero();
    drain();
    @(posedge clk);
    #1 reset = 1'b0;

    push_instr();
    push_instr();
    drain();

    for (int i = 0; i < 10; i++) begin
      set_instr(prog[i][11:6], prog[i][5:0]);
      push_instr();
      drain();
    end

    set_instr(6'b000000, 6'b100000);
    INT = 1'b1; INTD = 1'b1;
    push_instr();
    drain();

    INTD = 1'b0;
    if (INT_EN) push_intr();
    push_instr();
    push_instr();
    drain();
    INT = 1'b0;

    NMI = 1'b1;
    push_instr();
    if (INT_EN) push_intr();
    drain();
    NMI = 1'b0;

    set_instr(6'b010000, 6'b011000);
    push_instr();
    drain();

    set_instr(6'b000000, 6'b100000);
    push_instr();
    drain();

    set_instr(6'b100011, 6'b000000);
    push_state(B_FETCH);
    push_state(B_DECODE);
    push_state(B_MEMADR);
    push_state(B_MEMRD);
    drain();
    reset = 1'b1;
    push_zero();
    push_zero();
    drain();
    @(posedge clk);
    #1 reset = 1'b0;
    push_instr();
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish within budget");
    $fatal(1, "timeout");
  end

endmodule
